blockram_system_v1_nios2_cpu_debug_mem_agent: RTL and testbench

//  Debug-side consumer of the JTAG debug slave's sysclk outputs (jdo, take_*_ocimem_*).

---
 rtl/blockram_system_v1_nios2_cpu_debug_mem_agent.sv | 180 ++++++++++++++++++
 tb/tb_blockram_system_v1_nios2_cpu_debug_mem_agent.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockram_system_v1_nios2_cpu_debug_mem_agent.sv
// Debug memory agent: single-port 32-bit debug RAM shared between the JTAG debug slave
// (MonAReg/MonDReg word access) and a CPU Avalon-MM slave port, with starvation-bounded arbitration.
module blockram_system_v1_nios2_cpu_debug_mem_agent #(
  parameter int ADDR_W = 8,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  input  logic              av_debugaccess,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  typedef enum logic [1:0] {IDLE, AV_RD, J_RD, J_CAP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              pend;
  logic              pend_wr;
  logic              pend_inc;
  logic [31:0]       pend_data;
  logic [SW-1:0]     starve;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ram_q;

  logic              av_req;
  logic              j_grant;
  logic              strobe;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              unused_jdo;

  assign unused_jdo  = ^{jdo[37:36], jdo[2:0]};
  assign av_req      = av_read | av_write;
  assign strobe      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // Avalon normally wins; a JTAG request that has waited STARVE cycles takes the port anyway.
  assign j_grant     = (state == IDLE) && pend && (!av_req || (starve >= STARVE_MAX));
  assign av_readdata = ram_q;

  // Port mux and waitrequest; waitrequest must respond in the request cycle so it stays combinational.
  always_comb begin
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    ram_addr       = mon_a_reg;
    ram_wdata      = pend_data;
    ram_be         = 4'hF;
    av_waitrequest = 1'b0;
    case (state)
      IDLE: begin
        if (j_grant) begin
          av_waitrequest = av_req;
          ram_we         = pend_wr;
        end else if (av_write) begin
          ram_we    = av_debugaccess;
          ram_addr  = av_address;
          ram_wdata = av_writedata;
          ram_be    = av_byteenable;
        end else if (av_read) begin
          ram_re         = 1'b1;
          ram_addr       = av_address;
          av_waitrequest = 1'b1;
        end
      end
      AV_RD:   av_waitrequest = av_write;
      J_RD: begin
        ram_re         = 1'b1;
        av_waitrequest = av_req;
      end
      J_CAP:   av_waitrequest = av_req;
      default: av_waitrequest = av_req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ram_q <= '0;
    else if (ram_re) ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (take_action_ocimem_b && !pend) pend_data <= jdo[34:3];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      pend          <= 1'b0;
      pend_wr       <= 1'b0;
      pend_inc      <= 1'b0;
      starve        <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      if (j_grant) starve <= '0;
      else if (pend && (starve != STARVE_MAX)) starve <= starve + SW'(1);

      case (state)
        IDLE: begin
          if (j_grant) begin
            if (pend_wr) begin
              pend          <= 1'b0;
              monitor_ready <= 1'b1;
              mon_a_reg     <= mon_a_reg + ADDR_W'(1);
            end else begin
              state <= J_RD;
            end
          end else if (av_read && !av_write) begin
            state <= AV_RD;
          end
        end
        AV_RD: state <= IDLE;
        J_RD:  state <= J_CAP;
        J_CAP: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          pend          <= 1'b0;
          if (pend_inc) mon_a_reg <= mon_a_reg + ADDR_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // New strobes are only taken with nothing outstanding, so they never collide with the
      // completion updates above (those only fire while pend is set).
      if (strobe) begin
        if (pend) begin
          monitor_error <= 1'b1;
        end else if (take_action_ocimem_a) begin
          mon_a_reg <= jdo[17 +: ADDR_W];
          if (jdo[33]) monitor_error <= 1'b0;
          if (jdo[35]) begin
            pend          <= 1'b1;
            monitor_ready <= 1'b0;
            pend_wr       <= 1'b0;
            pend_inc      <= 1'b0;
          end
        end else if (take_no_action_ocimem_a) begin
          pend          <= 1'b1;
          monitor_ready <= 1'b0;
          pend_wr       <= 1'b0;
          pend_inc      <= 1'b1;
        end else begin
          pend          <= 1'b1;
          monitor_ready <= 1'b0;
          pend_wr       <= 1'b1;
          pend_inc      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_blockram_system_v1_nios2_cpu_debug_mem_agent.sv
// Scoreboard bench for the debug memory agent: directed JTAG and Avalon traffic,
// expected read data queued at issue time and checked by an independent monitor.
module tb_blockram_system_v1_nios2_cpu_debug_mem_agent;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [7:0]  av_address = '0;
  logic        av_read = 1'b0;
  logic        av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [3:0]  av_byteenable = '0;
  logic        av_debugaccess = 1'b0;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] av_exp_q[$];
  logic [31:0] j_exp_q[$];
  logic [31:0] last_rd = '0;
  logic        prev_ready = 1'b1;

  blockram_system_v1_nios2_cpu_debug_mem_agent #(.ADDR_W(8), .STARVE(4)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_debugaccess          (av_debugaccess),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: Avalon read completions and JTAG completions (monitor_ready rising).
  always @(negedge clk) begin
    if (reset_n && av_read && !av_waitrequest) begin
      if (av_exp_q.size() == 0) check("av_unexpected_rd", 32'd1, 32'd0);
      else check("av_readdata", av_readdata, av_exp_q.pop_front());
    end
    if (reset_n && monitor_ready && !prev_ready) begin
      if (j_exp_q.size() == 0) check("jtag_unexpected_done", 32'd1, 32'd0);
      else check("MonDReg", MonDReg, j_exp_q.pop_front());
    end
    prev_ready = monitor_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic rd, input logic clr);
    jdo = '0;
    jdo[24:17] = addr;
    jdo[35] = rd;
    jdo[33] = clr;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_na();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!monitor_ready && n < 50) begin
      tick();
      n++;
    end
    check("jtag_done", {31'd0, monitor_ready}, 32'd1);
  endtask

  task automatic av_rd(input logic [7:0] addr, input logic [31:0] exp, output int waits);
    av_exp_q.push_back(exp);
    av_address = addr;
    av_read = 1'b1;
    waits = 0;
    @(negedge clk);
    while (av_waitrequest && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    av_read = 1'b0;
    if (waits >= 40) check("av_rd_timeout", 32'(waits), 32'd0);
  endtask

  task automatic av_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be,
                       input logic dbg);
    int waits;
    av_address = addr;
    av_writedata = data;
    av_byteenable = be;
    av_debugaccess = dbg;
    av_write = 1'b1;
    waits = 0;
    @(negedge clk);
    while (av_waitrequest && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    av_write = 1'b0;
    av_debugaccess = 1'b0;
    if (waits >= 40) check("av_wr_timeout", 32'(waits), 32'd0);
  endtask

  initial begin
    int n;
    int w;

    // Reset state
    repeat (3) tick();
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_ready", {31'd0, monitor_ready}, 32'd1);
    check("rst_error", {31'd0, monitor_error}, 32'd0);
    check("rst_waitreq", {31'd0, av_waitrequest}, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // JTAG write then read-back at 0x10
    jtag_a(8'h10, 1'b0, 1'b0);
    check("addr_load_ready", {31'd0, monitor_ready}, 32'd1);
    j_exp_q.push_back(last_rd);
    jtag_b(32'hDEADBEEF);
    check("jwr_busy", {31'd0, monitor_ready}, 32'd0);
    wait_ready(n);
    check("jwr_latency", 32'(n), 32'd1);
    j_exp_q.push_back(32'hDEADBEEF);
    last_rd = 32'hDEADBEEF;
    jtag_a(8'h10, 1'b1, 1'b0);
    wait_ready(n);
    check("jrd_latency", 32'(n), 32'd3);
    check("jrd_MonDReg", MonDReg, 32'hDEADBEEF);
    j_exp_q.push_back(32'hDEADBEEF);
    jtag_na();
    wait_ready(n);

    // Avalon byte-lane writes and read
    av_wr(8'h11, 32'h11223344, 4'hF, 1'b1);
    av_wr(8'h11, 32'hAABBCCDD, 4'b0101, 1'b1);
    av_wr(8'h21, 32'h21212121, 4'hF, 1'b1);
    av_rd(8'h11, 32'h11BB33DD, w);
    check("av_rd_waits", 32'(w), 32'd1);

    // Starvation: Avalon reads held back-to-back while a JTAG read is pending
    jtag_a(8'h20, 1'b0, 1'b0);
    j_exp_q.push_back(last_rd);
    jtag_b(32'h01234567);
    wait_ready(n);
    j_exp_q.push_back(32'h01234567);
    last_rd = 32'h01234567;
    jtag_a(8'h20, 1'b1, 1'b0);
    av_rd(8'h11, 32'h11BB33DD, w);
    check("starve_rd1_waits", 32'(w), 32'd1);
    av_rd(8'h11, 32'h11BB33DD, w);
    check("starve_rd2_waits", 32'(w), 32'd1);
    av_rd(8'h11, 32'h11BB33DD, w);
    check("starve_rd3_waits", 32'(w), 32'd4);
    check("starve_jtag_done", {31'd0, monitor_ready}, 32'd1);

    // Overrun: second strobe one cycle after the first
    jtag_a(8'h20, 1'b0, 1'b0);
    j_exp_q.push_back(32'h01234567);
    jtag_na();
    jtag_b(32'hFFFFFFFF);
    wait_ready(n);
    check("overrun_error", {31'd0, monitor_error}, 32'd1);
    j_exp_q.push_back(32'h21212121);
    last_rd = 32'h21212121;
    jtag_na();
    wait_ready(n);
    check("error_sticky", {31'd0, monitor_error}, 32'd1);
    jtag_a(8'h00, 1'b0, 1'b1);
    check("error_clear", {31'd0, monitor_error}, 32'd0);

    // Address wrap and debugaccess-gated write
    j_exp_q.push_back(last_rd);
    jtag_b(32'h5A5A0000);
    wait_ready(n);
    jtag_a(8'hFF, 1'b0, 1'b0);
    j_exp_q.push_back(last_rd);
    jtag_b(32'h0000FFFF);
    wait_ready(n);
    jtag_a(8'hFF, 1'b0, 1'b0);
    j_exp_q.push_back(32'h0000FFFF);
    jtag_na();
    wait_ready(n);
    j_exp_q.push_back(32'h5A5A0000);
    last_rd = 32'h5A5A0000;
    jtag_na();
    wait_ready(n);
    av_wr(8'h00, 32'h12345678, 4'hF, 1'b0);
    av_rd(8'h00, 32'h5A5A0000, w);

    // Reset during J_RD
    jtag_na();
    tick();
    reset_n = 1'b0;
    #2;
    check("midrst_MonDReg", MonDReg, 32'h0);
    check("midrst_ready", {31'd0, monitor_ready}, 32'd1);
    check("midrst_waitreq", {31'd0, av_waitrequest}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("postrst_MonDReg", MonDReg, 32'h0);
    check("postrst_ready", {31'd0, monitor_ready}, 32'd1);
    av_rd(8'h10, 32'hDEADBEEF, w);
    check("postrst_av_waits", 32'(w), 32'd1);
    j_exp_q.push_back(32'h5A5A0000);
    jtag_na();
    wait_ready(n);
    check("postrst_jrd_latency", 32'(n), 32'd3);

    repeat (3) tick();
    check("av_queue_empty", 32'(av_exp_q.size()), 32'd0);
    check("jtag_queue_empty", 32'(j_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
